// File: rtl/ad_scan_ctrl.sv
// ad_scan_ctrl: Avalon-MM controlled scanner for a 16-clock serial ADC frame.
// A host picks channels via CHMASK and starts a scan. Each frame sends the
// address of the next channel on ad_din and reads back the conversion of the
// channel addressed in the previous frame. The first frame of each scan only
// primes the ADC pipeline.
// Optional feature: define AD_SCAN_IRQ_EN to add the irq output and CTRL.IRQ_EN.
module ad_scan_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        ad_cs_n,
    output logic        ad_sclk,
    output logic        ad_din,
    input  logic        ad_dout
`ifdef AD_SCAN_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [8:0] DIV_M1  = 9'(CLK_DIV - 1);
    localparam logic [8:0] DIV_M2  = 9'(CLK_DIV - 2);
    localparam logic [8:0] HOLD_M1 = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] CH_EN   = 8'((1 << NUM_CH) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        half_q, half_d;
    logic [11:0] shift_q, shift_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  addr_q, addr_d;
    logic        addr_vld_q, addr_vld_d;
    logic [2:0]  prev_addr_q, prev_addr_d;
    logic        prev_vld_q, prev_vld_d;
    logic        cont_q, cont_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic [7:0]  chmask_q, chmask_d;
    logic [11:0] result_q [8];
    logic [11:0] result_d [8];
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;

    logic        wr;
    logic        start_go;
    logic        busy;
    logic [7:0]  scan_mask;
    logic [2:0]  rd_ch;
    logic        unused_ok;

    assign wr        = chipselect & ~write_n;
    assign start_go  = wr && (address == 4'd0) && writedata[0];
    assign busy      = (state_q != ST_IDLE);
    assign scan_mask = chmask_q & CH_EN;
    assign rd_ch     = {address[3], address[1:0]};
    assign unused_ok = ^writedata[15:8];

    assign ad_cs_n = cs_n_q;
    assign ad_sclk = sclk_q;
    assign ad_din  = din_q;
`ifdef AD_SCAN_IRQ_EN
    assign irq = done_q & irq_en_q;
`endif

    // Lowest enabled channel in a mask (0 when the mask is empty).
    function automatic logic [2:0] first_ch(input logic [7:0] m);
        first_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) first_ch = 3'(i);
        end
    endfunction

    // Command bit for SCLK period k: address sits in periods 2..4, MSB first.
    function automatic logic frame_bit(input logic [3:0] k, input logic [2:0] a, input logic vld);
        case (k)
            4'd2:    frame_bit = a[2] & vld;
            4'd3:    frame_bit = a[1] & vld;
            4'd4:    frame_bit = a[0] & vld;
            default: frame_bit = 1'b0;
        endcase
    endfunction

    // Host read mux; RESULT reads see the pre-update value during an FSM write.
    always_comb begin
        readdata = 16'h0000;
        case (address)
            4'd0: readdata = {13'd0, irq_en_q, cont_q, 1'b0};
            4'd1: readdata = {14'd0, done_q, busy};
            4'd2: readdata = {8'd0, chmask_q};
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11:
                  readdata = {4'd0, result_q[rd_ch]};
            default: readdata = 16'h0000;
        endcase
    end

    // Register writes plus the scan FSM next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        half_d      = half_q;
        shift_d     = shift_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        addr_vld_d  = addr_vld_q;
        prev_addr_d = prev_addr_q;
        prev_vld_d  = prev_vld_q;
        cont_d      = cont_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        chmask_d    = chmask_q;
        result_d    = result_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        din_d       = din_q;

        if (wr && address == 4'd0) begin
            cont_d = writedata[1];
`ifdef AD_SCAN_IRQ_EN
            irq_en_d = writedata[2];
`endif
        end
`ifndef AD_SCAN_IRQ_EN
        irq_en_d = 1'b0;
`endif
        if (wr && address == 4'd1) done_d = 1'b0;
        if (wr && address == 4'd2) chmask_d = writedata[7:0];

        case (state_q)
            ST_IDLE: begin
                if (start_go && scan_mask != 8'd0) begin
                    state_d    = ST_SETUP;
                    cnt_d      = 9'd0;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b1;
                    din_d      = 1'b0;
                    addr_d     = first_ch(scan_mask);
                    addr_vld_d = 1'b1;
                    rem_d      = scan_mask & (scan_mask - 8'd1);
                    prev_vld_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == DIV_M1) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 9'd0;
                    bit_d   = 4'd0;
                    half_d  = 1'b0;
                    sclk_d  = 1'b0;
                    din_d   = frame_bit(4'd0, addr_q, addr_vld_q);
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_SHIFT: begin
                if (!half_q && cnt_q == DIV_M2) shift_d = {shift_q[10:0], ad_dout};
                if (cnt_q == DIV_M1) begin
                    cnt_d = 9'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        state_d = ST_HOLD;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        din_d   = 1'b0;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                        din_d  = frame_bit(bit_q + 4'd1, addr_q, addr_vld_q);
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_M1) begin
                    cnt_d = 9'd0;
                    if (prev_vld_q) result_d[prev_addr_q] = shift_q;
                    if (addr_vld_q) begin
                        state_d     = ST_SETUP;
                        cs_n_d      = 1'b0;
                        prev_addr_d = addr_q;
                        prev_vld_d  = 1'b1;
                        addr_vld_d  = (rem_q != 8'd0);
                        addr_d      = first_ch(rem_q);
                        rem_d       = rem_q & (rem_q - 8'd1);
                    end else begin
                        done_d = 1'b1;
                        if (cont_q && scan_mask != 8'd0) begin
                            state_d    = ST_SETUP;
                            cs_n_d     = 1'b0;
                            addr_d     = first_ch(scan_mask);
                            addr_vld_d = 1'b1;
                            rem_d      = scan_mask & (scan_mask - 8'd1);
                            prev_vld_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register flops; reset aborts any frame without a RESULT write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 9'd0;
            bit_q       <= 4'd0;
            half_q      <= 1'b0;
            shift_q     <= 12'd0;
            rem_q       <= 8'd0;
            addr_q      <= 3'd0;
            addr_vld_q  <= 1'b0;
            prev_addr_q <= 3'd0;
            prev_vld_q  <= 1'b0;
            cont_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            chmask_q    <= 8'd0;
            for (int i = 0; i < 8; i++) result_q[i] <= 12'd0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            din_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            half_q      <= half_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            addr_vld_q  <= addr_vld_d;
            prev_addr_q <= prev_addr_d;
            prev_vld_q  <= prev_vld_d;
            cont_q      <= cont_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            chmask_q    <= chmask_d;
            result_q    <= result_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            din_q       <= din_d;
        end
    end

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// Directed bench for ad_scan_ctrl with a behavioural serial ADC model.
module tb_ad_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int NUM_CH  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = 4'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'h0000;
    logic [15:0] readdata;
    logic        ad_cs_n;
    logic        ad_sclk;
    logic        ad_din;
    logic        ad_dout = 1'b0;
`ifdef AD_SCAN_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    ad_scan_ctrl #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .ad_cs_n    (ad_cs_n),
        .ad_sclk    (ad_sclk),
        .ad_din     (ad_din),
        .ad_dout    (ad_dout)
`ifdef AD_SCAN_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("pass %s value=0x%0h", tag, got);
        end
    endtask

    // Conversion value the model ADC returns per channel.
    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (ch)
            3'd0: adc_val = 12'hABC;
            3'd1: adc_val = 12'h123;
            3'd2: adc_val = 12'h456;
            3'd3: adc_val = 12'h789;
            3'd4: adc_val = 12'hDEF;
            3'd5: adc_val = 12'h321;
            3'd6: adc_val = 12'h654;
            default: adc_val = 12'h987;
        endcase
    endfunction

    // ADC model: watches cs_n/sclk each falling clk edge, captures the command
    // address on SCLK rises 2..4, shifts out {4'b0, value} on SCLK falls.
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    logic [2:0]  cur_addr = 3'd0;
    logic [2:0]  prev_addr = 3'd0;
    logic [15:0] out_word = 16'h0000;
    int          frames_started = 0;
    int          frames_done = 0;
    logic [2:0]  frame_addr [16];
    int          frame_rises [16];
    time         t_cs = 0;
    time         t_f1 = 0;
    time         t_f2 = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            rise_cnt = 0;
            fall_cnt = 0;
            cur_addr = 3'd0;
            prev_addr = 3'd0;
            frames_started = 0;
            frames_done = 0;
            ad_dout = 1'b0;
            cs_prev = 1'b1;
            sclk_prev = 1'b1;
            for (int i = 0; i < 16; i++) begin
                frame_addr[i] = 3'd0;
                frame_rises[i] = 0;
            end
        end else begin
            if (cs_prev && !ad_cs_n) begin
                frames_started++;
                rise_cnt = 0;
                fall_cnt = 0;
                cur_addr = 3'd0;
                out_word = {4'h0, adc_val(prev_addr)};
                ad_dout = 1'b0;
                if (frames_started == 1) t_cs = $time;
            end
            if (!ad_cs_n && sclk_prev && !ad_sclk) begin
                if (fall_cnt < 16) ad_dout = out_word[15 - fall_cnt];
                fall_cnt++;
                if (frames_started == 1 && fall_cnt == 1) t_f1 = $time;
                if (frames_started == 1 && fall_cnt == 2) t_f2 = $time;
            end
            if (!ad_cs_n && !sclk_prev && ad_sclk) begin
                if (rise_cnt == 2) cur_addr[2] = ad_din;
                if (rise_cnt == 3) cur_addr[1] = ad_din;
                if (rise_cnt == 4) cur_addr[0] = ad_din;
                rise_cnt++;
            end
            if (!cs_prev && ad_cs_n) begin
                if (frames_done < 16) begin
                    frame_addr[frames_done] = cur_addr;
                    frame_rises[frames_done] = rise_cnt;
                end
                frames_done++;
                prev_addr = cur_addr;
            end
            cs_prev = ad_cs_n;
            sclk_prev = ad_sclk;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        $display("write addr=%0d data=0x%04h", a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        chipselect = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic [15:0] st;
        int n;
        n = 0;
        st = 16'h0001;
        while (st[0] && n < budget) begin
            bus_read(4'd1, st);
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, st[0]}, 32'd0);
    endtask

    task automatic wait_started(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (frames_started < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_started"}, frames_started, target);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] rd;
        logic [15:0] exp_ctrl;
        logic [7:0]  m;
        logic [11:0] exp_res;
        int          exp_addr [4];
        int          k;

        exp_addr = '{0, 2, 5, 7};

        // Reset state, observed while reset is still held.
        @(negedge clk);
        #1;
        check_eq("rst_cs_n", {31'd0, ad_cs_n}, 32'd1);
        check_eq("rst_sclk", {31'd0, ad_sclk}, 32'd1);
        check_eq("rst_din", {31'd0, ad_din}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(4'd0, rd);  check_eq("rst_ctrl", {16'd0, rd}, 32'h0);
        bus_read(4'd1, rd);  check_eq("rst_status", {16'd0, rd}, 32'h0);
        bus_read(4'd2, rd);  check_eq("rst_chmask", {16'd0, rd}, 32'h0);
        bus_read(4'd4, rd);  check_eq("rst_result0", {16'd0, rd}, 32'h0);
        bus_read(4'd11, rd); check_eq("rst_result7", {16'd0, rd}, 32'h0);

        // CTRL readback: IRQ_EN bit exists only with the feature.
`ifdef AD_SCAN_IRQ_EN
        exp_ctrl = 16'h0006;
`else
        exp_ctrl = 16'h0002;
`endif
        bus_write(4'd0, 16'h0006);
        bus_read(4'd0, rd);  check_eq("ctrl_readback", {16'd0, rd}, {16'd0, exp_ctrl});
        bus_write(4'd0, 16'h0000);

        // START with empty CHMASK is ignored.
        bus_write(4'd0, 16'h0001);
        bus_read(4'd1, rd);  check_eq("start_mask0_status", {16'd0, rd}, 32'h0);
        repeat (10) @(negedge clk);
        check_eq("start_mask0_cs_n", {31'd0, ad_cs_n}, 32'd1);

        // Single channel scan with frame timing.
        do_reset();
        bus_write(4'd2, 16'h0001);
        bus_write(4'd0, 16'h0001);
        bus_read(4'd1, rd);  check_eq("ch0_busy", {16'd0, rd}, 32'h1);
        wait_idle("ch0", 3000);
        check_eq("ch0_frames", frames_done, 2);
        check_eq("ch0_frame0_addr", {29'd0, frame_addr[0]}, 32'd0);
        check_eq("ch0_rises_f0", frame_rises[0], 16);
        check_eq("ch0_rises_f1", frame_rises[1], 16);
        check_eq("ch0_cs_to_fall_ns", 32'(t_f1 - t_cs), 32'd40);
        check_eq("ch0_sclk_period_ns", 32'(t_f2 - t_f1), 32'd80);
        bus_read(4'd4, rd);  check_eq("ch0_result0", {16'd0, rd}, 32'hABC);
        bus_read(4'd5, rd);  check_eq("ch0_result1", {16'd0, rd}, 32'h0);
        bus_read(4'd1, rd);  check_eq("ch0_status_done", {16'd0, rd}, 32'h2);
        bus_write(4'd1, 16'h0000);
        bus_read(4'd1, rd);  check_eq("ch0_status_clr", {16'd0, rd}, 32'h0);
        bus_read(4'd4, rd);  check_eq("ch0_result0_kept", {16'd0, rd}, 32'hABC);

        // Sparse mask, with CHMASK rewrite and START while busy.
        do_reset();
        bus_write(4'd2, 16'h00A5);
        bus_write(4'd0, 16'h0001);
        bus_write(4'd2, 16'h00FF);
        bus_write(4'd0, 16'h0001);
        wait_idle("a5", 5000);
        check_eq("a5_frames", frames_done, 5);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("a5_addr_f%0d", i), {29'd0, frame_addr[i]}, exp_addr[i]);
        m = 8'hA5;
        for (int ch = 0; ch < 8; ch++) begin
            exp_res = m[ch] ? adc_val(3'(ch)) : 12'd0;
            bus_read(4'(4 + ch), rd);
            check_eq($sformatf("a5_result%0d", ch), {16'd0, rd}, {20'd0, exp_res});
        end
        bus_read(4'd2, rd);  check_eq("a5_chmask_new", {16'd0, rd}, 32'hFF);
        bus_read(4'd1, rd);  check_eq("a5_status", {16'd0, rd}, 32'h2);

        // Continuous mode, CONT cleared during the second scan.
        do_reset();
        bus_write(4'd2, 16'h0003);
        bus_write(4'd0, 16'h0003);
        wait_started("cont", 4, 3000);
        bus_write(4'd0, 16'h0000);
        wait_idle("cont", 5000);
        check_eq("cont_frames", frames_done, 6);
        check_eq("cont_s2_f0_addr", {29'd0, frame_addr[3]}, 32'd0);
        check_eq("cont_s2_f1_addr", {29'd0, frame_addr[4]}, 32'd1);
        bus_read(4'd4, rd);  check_eq("cont_result0", {16'd0, rd}, 32'hABC);
        bus_read(4'd5, rd);  check_eq("cont_result1", {16'd0, rd}, 32'h123);
        repeat (200) @(negedge clk);
        check_eq("cont_no_restart", frames_started, 6);

        // Reset asserted at the 9th SCLK fall of the data frame.
        do_reset();
        bus_write(4'd2, 16'h0001);
        bus_write(4'd0, 16'h0001);
        k = 0;
        while (!(frames_started == 2 && fall_cnt == 9) && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_eq("abort_fall_cnt", fall_cnt, 9);
        check_eq("abort_pre_sclk", {31'd0, ad_sclk}, 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("abort_cs_n", {31'd0, ad_cs_n}, 32'd1);
        check_eq("abort_sclk", {31'd0, ad_sclk}, 32'd1);
        check_eq("abort_din", {31'd0, ad_din}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("abort_idle_cs_n", {31'd0, ad_cs_n}, 32'd1);
        bus_read(4'd4, rd);  check_eq("abort_result0", {16'd0, rd}, 32'h0);
        bus_read(4'd1, rd);  check_eq("abort_status", {16'd0, rd}, 32'h0);

`ifdef AD_SCAN_IRQ_EN
        // Interrupt follows DONE when enabled.
        do_reset();
        bus_write(4'd2, 16'h0001);
        bus_write(4'd0, 16'h0005);
        wait_idle("irq", 3000);
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        bus_write(4'd1, 16'h0000);
        check_eq("irq_clr", {31'd0, irq}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_scan_ctrl.md
AD_SCAN_CTRL -- requirements
Module: ad_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SCLK half-period in clk cycles (legal 2..255).
REQ-002 SHALL have parameter NUM_CH, default 8, meaning number of ADC channels scanned (legal 1..8).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  4  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  16  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  16  Avalon-MM read data, combinational from address, zero wait states.
REQ-010 SHALL have ports ad_cs_n, ad_sclk, ad_din  output  1 each  serial ADC chip select, clock, command data.
REQ-011 SHALL have port ad_dout  input  1  serial ADC conversion data.

Function
REQ-012 SHALL decode registers: 0 CTRL (bit0 START write-1 self-clearing, bit1 CONT), 1 STATUS (bit0 BUSY, bit1 DONE), 2 CHMASK[7:0], 4..11 RESULT[ch][11:0]; other addresses read 0.
REQ-013 SHALL clear DONE on any write to STATUS; write to STATUS has no other effect.
REQ-014 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> (SETUP | IDLE).
REQ-015 SHALL leave IDLE only when START written with CHMASK nonzero; START with CHMASK=0 is ignored, DONE unchanged.
REQ-016 SHALL, in SETUP, drive ad_cs_n low for CLK_DIV clk cycles with ad_sclk high.
REQ-017 SHALL, in SHIFT, generate 16 SCLK periods, each low CLK_DIV then high CLK_DIV cycles.
REQ-018 SHALL update ad_din on each SCLK falling edge, MSB first: frame bits 2..4 = address of next enabled channel, all other bits 0.
REQ-019 SHALL sample ad_dout one clk cycle before each SCLK rising edge; bits 4..15 form the 12-bit result, MSB first.
REQ-020 SHALL, in HOLD, drive ad_cs_n high for 2*CLK_DIV cycles, then write result of frame i into RESULT of channel addressed in frame i-1.
REQ-021 SHALL issue one priming frame at scan start; its data is discarded.
REQ-022 SHALL scan enabled channels in ascending order; one scan is NUM_CH-limited CHMASK popcount + 1 frames.
REQ-023 SHALL, at end of scan, set DONE; if CONT=1, restart immediately with priming frame, else go IDLE.
REQ-024 SHALL latch CHMASK at scan start; CHMASK writes during a scan take effect next scan.
REQ-025 SHALL, on CONT cleared mid-scan, finish current scan then go IDLE.
REQ-026 SHALL ignore START while BUSY.
REQ-027 SHALL, when RESULT written by FSM and read by host in same cycle, return old value that cycle.
REQ-028 SHALL assert BUSY in every state except IDLE.

Reset
REQ-029 SHALL, during reset, force ad_cs_n=1, ad_sclk=1, ad_din=0, FSM IDLE, CTRL=0, STATUS=0, CHMASK=0, all RESULT=0.
REQ-030 SHALL, on reset mid-frame, abort immediately with no partial RESULT write.

Configuration
REQ-031 SHALL, with macro AD_SCAN_IRQ_EN defined, add output irq (1 bit) and CTRL bit2 IRQ_EN; irq = DONE & IRQ_EN, cleared with DONE.
REQ-032 SHALL, without AD_SCAN_IRQ_EN, have no irq port, CTRL bit2 reads 0 and ignores writes.

Verification
REQ-033 SHALL cover: CHMASK=0x01, START, model returns 0xABC -> 2 frames, RESULT0=0xABC, DONE=1, BUSY=0.
REQ-034 SHALL cover: CHMASK=0xA5 -> ad_din addresses 0,2,5,7 in frames 0..3, 5 frames, RESULT for ch 0,2,5,7 match model, others 0.
REQ-035 SHALL cover: CLK_DIV=4 -> SCLK period 8 clk, cs_n low to first fall 4 clk, 16 SCLK edges per frame.
REQ-036 SHALL cover: CONT=1, CHMASK=0x03, clear CONT in scan 2 -> exactly 2 scans, then IDLE.
REQ-037 SHALL cover: reset_n low at SCLK edge 9 -> outputs cs_n=1, sclk=1, din=0 same cycle, RESULT unchanged at 0.
REQ-038 SHALL cover: with AD_SCAN_IRQ_EN, IRQ_EN=1, scan completes -> irq=1; write STATUS -> irq=0 next cycle.
